control_unit_mc: RTL and testbench

Parametrised multicycle control unit for the K&S datapath, successor to the fixed fetch/decode/load sequencer. It adds a configurable memory latency for instruction fetch and data load, and implements all six conditional branches. It widens the ALU operation field so OR has its own encoding, and selects the overflow-branch source by parameter. It also keeps a saturating retired-instruction counter. It sits between the instruction decoder/flag register and the datapath/RAM enables, with the same enable semantics the datapath already uses.

---
 rtl/control_unit_mc.sv | 169 ++++++++++++++++
 tb/tb_control_unit_mc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_mc.sv
// Multicycle control unit for the K&S datapath: fetch/decode/load sequencing with
// configurable RAM latency, six conditional branches and a saturating retire counter.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_STORE, I_LOAD,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;
endpackage

module control_unit_mc
    import k_and_s_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int OP_WIDTH    = 3,
    parameter int OV_SEL      = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [OP_WIDTH-1:0]     operation,
    output logic [CNT_WIDTH-1:0]    instr_count
);
    typedef enum logic [2:0] {
        S_FETCH, S_LATCH_IR, S_DECODE, S_LOAD_WAIT, S_LOAD_WB, S_HALTED
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LATENCY - 1);

    state_t               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 retire;
    logic                 sel_ov;
    logic                 cond_taken;

    assign sel_ov = (OV_SEL != 0) ? unsigned_overflow : signed_overflow;

    always_comb begin
        cond_taken = 1'b0;
        case (decoded_instruction)
            I_BZERO:  cond_taken = zero_op;
            I_BNZERO: cond_taken = !zero_op;
            I_BNEG:   cond_taken = neg_op;
            I_BNNEG:  cond_taken = !neg_op;
            I_BOV:    cond_taken = sel_ov;
            I_BNOV:   cond_taken = !sel_ov;
            default:  cond_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            wait_q  <= 4'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // The wait counter only advances while dwelling; any state change clears it.
    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (wait_q == LAST_WAIT) state_d = S_LATCH_IR;
                else                     wait_d  = wait_q + 4'd1;
            end
            S_LATCH_IR: state_d = S_DECODE;
            S_DECODE: begin
                if (decoded_instruction == I_LOAD) begin
                    state_d = S_LOAD_WAIT;
                end else begin
                    retire  = 1'b1;
                    state_d = (decoded_instruction == I_HALT) ? S_HALTED : S_FETCH;
                end
            end
            S_LOAD_WAIT: begin
                if (wait_q == LAST_WAIT) state_d = S_LOAD_WB;
                else                     wait_d  = wait_q + 4'd1;
            end
            S_LOAD_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
        count_d = (retire && (count_q != '1)) ? count_q + 1'b1 : count_q;
    end

    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        operation        = '0;
        case (state_q)
            S_LATCH_IR: begin
                ir_enable = 1'b1;
                pc_enable = 1'b1;
            end
            S_DECODE: begin
                case (decoded_instruction)
                    I_MOVE: write_reg_enable = 1'b1;
                    I_ADD, I_SUB, I_AND, I_OR: begin
                        write_reg_enable = 1'b1;
                        flags_reg_enable = 1'b1;
                        case (decoded_instruction)
                            I_ADD:   operation = OP_WIDTH'(1);
                            I_SUB:   operation = OP_WIDTH'(2);
                            I_AND:   operation = OP_WIDTH'(3);
                            default: operation = OP_WIDTH'(4);
                        endcase
                    end
                    I_STORE: begin
                        addr_sel         = 1'b1;
                        ram_write_enable = 1'b1;
                    end
                    I_LOAD: addr_sel = 1'b1;
                    I_BRANCH: begin
                        branch    = 1'b1;
                        pc_enable = 1'b1;
                    end
                    default: begin
                        branch    = cond_taken;
                        pc_enable = cond_taken;
                    end
                endcase
            end
            S_LOAD_WAIT: begin
                addr_sel = 1'b1;
                c_sel    = 1'b1;
            end
            S_LOAD_WB: begin
                addr_sel         = 1'b1;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
            end
            S_HALTED: halt = 1'b1;
            default: ;
        endcase
    end

    assign instr_count = count_q;
endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: three parameterisations fed common stimulus, checked every
// cycle against an instruction-position model, plus directed literal checks.
module tb_control_unit_mc;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    decoded_instruction_type instr = I_NOP;
    logic z = 1'b0, n = 1'b0, u = 1'b0, s = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // ctl order: branch pc ir wr addr c flags ramwr halt
    logic [8:0]  act_ctl [3];
    logic [2:0]  act_op  [3];
    logic [15:0] act_cnt [3];
    logic [8:0]  exp_ctl [3];
    logic [2:0]  exp_op  [3];
    logic [15:0] exp_cnt [3];

    // Expected outputs from the position within the current instruction:
    // 0..L-1 fetch wait, L latch, L+1 decode, L+2..2L+1 load wait, 2L+2 load writeback.
    function automatic logic [11:0] model_out(int pos, bit halted, int L, int ovsel,
                                              decoded_instruction_type ins,
                                              logic zf, logic nf, logic uf, logic sf);
        logic br = 0, pc = 0, ir = 0, wr = 0, as = 0, cs = 0, fe = 0, rw = 0, h = 0;
        logic [2:0] op = 3'd0;
        logic ov = (ovsel != 0) ? uf : sf;
        logic take = 0;
        if (halted) h = 1;
        else if (pos < L) ;
        else if (pos == L) begin ir = 1; pc = 1; end
        else if (pos == L + 1) begin
            if (ins == I_MOVE) wr = 1;
            else if (ins == I_ADD) begin op = 1; wr = 1; fe = 1; end
            else if (ins == I_SUB) begin op = 2; wr = 1; fe = 1; end
            else if (ins == I_AND) begin op = 3; wr = 1; fe = 1; end
            else if (ins == I_OR)  begin op = 4; wr = 1; fe = 1; end
            else if (ins == I_STORE) begin as = 1; rw = 1; end
            else if (ins == I_LOAD) as = 1;
            else if (ins == I_BRANCH) take = 1;
            else if (ins == I_BZERO)  take = zf;
            else if (ins == I_BNZERO) take = !zf;
            else if (ins == I_BNEG)   take = nf;
            else if (ins == I_BNNEG)  take = !nf;
            else if (ins == I_BOV)    take = ov;
            else if (ins == I_BNOV)   take = !ov;
            br = take; pc = take;
        end
        else if (pos <= 2 * L + 1) begin as = 1; cs = 1; end
        else begin as = 1; cs = 1; wr = 1; end
        return {br, pc, ir, wr, as, cs, fe, rw, h, op};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int ML  = (gi == 0) ? 1 : (gi == 1) ? 3 : 2;
        localparam int OVS = (gi == 1) ? 1 : 0;
        localparam int CW  = (gi == 0) ? 16 : (gi == 1) ? 4 : 2;

        logic br, pc, ir, wr, as, cs, fe, rw, h;
        logic [2:0]    op;
        logic [CW-1:0] cnt;

        control_unit_mc #(.MEM_LATENCY(ML), .OP_WIDTH(3), .OV_SEL(OVS), .CNT_WIDTH(CW)) u_dut (
            .clk(clk), .rst_n(rst_n), .decoded_instruction(instr),
            .zero_op(z), .neg_op(n), .unsigned_overflow(u), .signed_overflow(s),
            .branch(br), .pc_enable(pc), .ir_enable(ir), .write_reg_enable(wr),
            .addr_sel(as), .c_sel(cs), .flags_reg_enable(fe), .ram_write_enable(rw),
            .halt(h), .operation(op), .instr_count(cnt)
        );

        assign act_ctl[gi] = {br, pc, ir, wr, as, cs, fe, rw, h};
        assign act_op[gi]  = op;
        assign act_cnt[gi] = 16'(cnt);

        int pos_m, cnt_m;
        bit halted_m;
        localparam int CMAX = (1 << CW) - 1;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pos_m <= 0; cnt_m <= 0; halted_m <= 0;
            end else if (!halted_m) begin
                if (pos_m == ML + 1) begin
                    if (instr == I_LOAD) pos_m <= pos_m + 1;
                    else begin
                        pos_m <= 0;
                        cnt_m <= (cnt_m < CMAX) ? cnt_m + 1 : cnt_m;
                        if (instr == I_HALT) halted_m <= 1;
                    end
                end else if (pos_m == 2 * ML + 2) begin
                    pos_m <= 0;
                    cnt_m <= (cnt_m < CMAX) ? cnt_m + 1 : cnt_m;
                end else pos_m <= pos_m + 1;
            end
        end

        logic [11:0] m;
        assign m = model_out(pos_m, halted_m, ML, OVS, instr, z, n, u, s);
        assign exp_ctl[gi] = m[11:3];
        assign exp_op[gi]  = m[2:0];
        assign exp_cnt[gi] = 16'(cnt_m);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                n_checks += 3;
                if (act_ctl[i] !== exp_ctl[i]) begin
                    n_fail++;
                    $display("FAIL model_ctl inst%0d t=%0t: got %b expected %b", i, $time, act_ctl[i], exp_ctl[i]);
                end
                if (act_op[i] !== exp_op[i]) begin
                    n_fail++;
                    $display("FAIL model_op inst%0d t=%0t: got %0d expected %0d", i, $time, act_op[i], exp_op[i]);
                end
                if (act_cnt[i] !== exp_cnt[i]) begin
                    n_fail++;
                    $display("FAIL model_cnt inst%0d t=%0t: got %0d expected %0d", i, $time, act_cnt[i], exp_cnt[i]);
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    decoded_instruction_type prog [4];
    int exp_ops [4];

    initial begin
        prog    = '{I_ADD, I_SUB, I_OR, I_MOVE};
        exp_ops = '{1, 2, 4, 0};

        // ADD SUB OR MOVE on the latency-1 unit
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            instr = (c < 12) ? prog[c / 3] : I_NOP;
            @(negedge clk);
            if (c % 3 == 2) begin
                chk($sformatf("alu_op c%0d", c), act_op[0], exp_ops[c / 3]);
                chk($sformatf("alu_flags_en c%0d", c), act_ctl[0][2], (c / 3 < 3) ? 1 : 0);
            end
            if (c == 12) chk("alu_count", act_cnt[0], 4);
            next_cycle();
        end

        // LOAD on the latency-2 unit
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            instr = I_LOAD;
            @(negedge clk);
            if (c < 7) begin
                chk($sformatf("load_addr_sel c%0d", c), act_ctl[2][4], (c >= 3) ? 1 : 0);
                chk($sformatf("load_c_sel c%0d", c), act_ctl[2][3], (c >= 4) ? 1 : 0);
                chk($sformatf("load_wr c%0d", c), act_ctl[2][5], (c == 6) ? 1 : 0);
            end else begin
                chk("load_count", act_cnt[2], 1);
                chk("load_back_to_fetch", act_ctl[2][4], 0);
            end
            next_cycle();
        end

        // zero/neg branches on the latency-1 unit
        z = 1; n = 0;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            instr = (c < 3) ? I_BZERO : (c < 6) ? I_BNZERO : I_BNNEG;
            @(negedge clk);
            if (c == 2) chk("bzero_taken", act_ctl[0][8:7], 3);
            if (c == 5) chk("bnzero_not_taken", act_ctl[0][8:7], 0);
            if (c == 8) chk("bnneg_taken", act_ctl[0][8:7], 3);
            next_cycle();
        end

        // overflow source selection: inst0 signed, inst1 unsigned
        s = 1; u = 0;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int c = 0; c < 5; c++) begin
                instr = (pass == 0) ? I_BOV : I_BNOV;
                @(negedge clk);
                if (c == 2) chk($sformatf("ov_signed pass%0d", pass), act_ctl[0][8], (pass == 0) ? 1 : 0);
                if (c == 4) chk($sformatf("ov_unsigned pass%0d", pass), act_ctl[1][8], (pass == 0) ? 0 : 1);
                next_cycle();
            end
        end

        // 2-bit counter saturation and halt on the latency-2 unit
        do_reset();
        for (int c = 0; c < 44; c++) begin
            instr = (c / 4 < 5) ? I_NOP : I_HALT;
            @(negedge clk);
            if (c >= 4 && c % 4 == 0 && c <= 24)
                chk($sformatf("sat_count c%0d", c), act_cnt[2], (c / 4 < 3) ? c / 4 : 3);
            if (c == 23) chk("halt_low_in_decode", act_ctl[2][0], 0);
            if (c >= 24) chk($sformatf("halt_held c%0d", c), act_ctl[2][0], 1);
            next_cycle();
        end

        // async reset in the middle of a load wait on the latency-3 unit
        do_reset();
        for (int c = 0; c < 11; c++) begin
            instr = (c < 5) ? I_NOP : I_LOAD;
            @(negedge clk);
            if (c == 10) begin
                chk("preset_count", act_cnt[1], 1);
                chk("preset_in_load_wait", act_ctl[1][3], 1);
            end
            next_cycle();
        end
        rst_n = 1'b0;
        #1;
        chk("reset_ctl_zero", act_ctl[1], 0);
        chk("reset_op_zero", act_op[1], 0);
        chk("reset_count_zero", act_cnt[1], 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            instr = I_NOP;
            @(negedge clk);
            chk($sformatf("post_reset_ir c%0d", c), act_ctl[1][6], (c == 3) ? 1 : 0);
            next_cycle();
        end

        // randomized segments checked by the model every cycle
        for (int seg = 0; seg < 5; seg++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                instr = decoded_instruction_type'($urandom_range(0, 15));
                if (instr == I_HALT && $urandom_range(0, 15) != 0) instr = I_NOP;
                z = 1'($urandom); n = 1'($urandom);
                u = 1'($urandom); s = 1'($urandom);
                next_cycle();
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
